// File: rtl/modulo_exponent.sv
// modulo_exponent: o_result = i_base^i_exp mod i_n using right-to-left
// square-and-multiply. It time-shares one external modular multiplier over a
// start/finished handshake.
// Optional feature macro: EXP_EARLY_EXIT_EN. When it is defined, the walk stops
// once the remaining exponent bits are zero. When it is undefined, all WIDTH
// bits are walked so the latency is constant.
`ifndef MAX_BITS
`define MAX_BITS 256
`endif

module modulo_exponent #(
  parameter int WIDTH = `MAX_BITS
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_n,
  input  logic [WIDTH-1:0] i_base,
  input  logic [WIDTH-1:0] i_exp,
  output logic [WIDTH-1:0] o_result,
  output logic             o_finished,
  output logic             o_busy,
  output logic             o_mul_start,
  output logic [WIDTH-1:0] o_mul_a,
  output logic [WIDTH-1:0] o_mul_b,
  output logic [WIDTH-1:0] o_mul_n,
  input  logic [WIDTH-1:0] i_mul_result,
  input  logic             i_mul_finished
);

  localparam int KW = $clog2(WIDTH) + 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CHECK    = 3'd1;
  localparam logic [2:0] MUL_REQ  = 3'd2;
  localparam logic [2:0] MUL_WAIT = 3'd3;
  localparam logic [2:0] SQR_REQ  = 3'd4;
  localparam logic [2:0] SQR_WAIT = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  logic [2:0]       state;
  logic [WIDTH-1:0] r_q, b_q, e_q, n_q;
  logic [KW-1:0]    k_q;
  logic             last_bit;

  // The current bit is the last one to process. No squaring is issued after it.
`ifdef EXP_EARLY_EXIT_EN
  assign last_bit = (k_q == KW'(WIDTH - 1)) || ((e_q >> 1) == '0);
`else
  assign last_bit = (k_q == KW'(WIDTH - 1));
`endif

  assign o_finished = (state == DONE);
  assign o_busy     = (state != IDLE);
  assign o_mul_n    = n_q;

  // Main sequencer. Operands are loaded on the edge into a REQ state and are
  // held untouched until the next REQ, so they stay stable across the wait.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= IDLE;
      r_q         <= WIDTH'(1);
      b_q         <= '0;
      e_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      o_result    <= '0;
      o_mul_start <= 1'b0;
      o_mul_a     <= '0;
      o_mul_b     <= '0;
    end else begin
      o_mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            n_q   <= i_n;
            b_q   <= i_base;
            e_q   <= i_exp;
            r_q   <= WIDTH'(1);
            k_q   <= '0;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (e_q[0]) begin
            o_mul_start <= 1'b1;
            o_mul_a     <= r_q;
            o_mul_b     <= b_q;
            state       <= MUL_REQ;
          end else if (last_bit) begin
            o_result <= r_q;
            state    <= DONE;
          end else begin
            o_mul_start <= 1'b1;
            o_mul_a     <= b_q;
            o_mul_b     <= b_q;
            state       <= SQR_REQ;
          end
        end
        MUL_REQ: state <= MUL_WAIT;
        MUL_WAIT: begin
          if (i_mul_finished) begin
            r_q <= i_mul_result;
            if (last_bit) begin
              o_result <= i_mul_result;
              state    <= DONE;
            end else begin
              o_mul_start <= 1'b1;
              o_mul_a     <= b_q;
              o_mul_b     <= b_q;
              state       <= SQR_REQ;
            end
          end
        end
        SQR_REQ: state <= SQR_WAIT;
        SQR_WAIT: begin
          if (i_mul_finished) begin
            b_q   <= i_mul_result;
            e_q   <= e_q >> 1;
            k_q   <= k_q + KW'(1);
            state <= CHECK;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/modulo_exponent.md
# modulo_exponent

- Computes `o_result = i_base^i_exp mod i_n` by right-to-left square-and-multiply.
- Acts as the initiator of the start/finished modular-multiplier handshake and drives an external modular multiplier for every product.
- Sits above the multiplier in the ECC arithmetic datapath; it serves field inversion (Fermat: a^(n-2)) and other exponentiations.
- Holds no multiplier of its own: one multiplier instance is time-shared for both multiply and square steps.

## Interface
- `WIDTH`, default `` `MAX_BITS `` (256): operand/modulus width.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  request; sampled only in IDLE.
- `i_n`  in  WIDTH  modulus. Caller guarantees n > 1.
- `i_base`  in  WIDTH  base. Caller guarantees base < n.
- `i_exp`  in  WIDTH  exponent.
- `o_result`  out  WIDTH  final value; held until the next accepted start.
- `o_finished`  out  1  one-cycle done pulse.
- `o_busy`  out  1  high from the cycle after start acceptance through the DONE cycle.
- `o_mul_start`  out  1  one-cycle multiplier request.
- `o_mul_a`, `o_mul_b`  out  WIDTH  multiplier operands.
- `o_mul_n`  out  WIDTH  modulus to the multiplier (captured n).
- `i_mul_result`  in  WIDTH  multiplier product.
- `i_mul_finished`  in  1  multiplier one-cycle done pulse; `i_mul_result` is valid in that cycle.

## Operation
- **Start:** on `i_start` in IDLE, capture n, base→B, exp→E. Set R=1 and bit index k=0.
- **Busy:** `i_start` is ignored while busy.
- **States:** IDLE, CHECK, MUL_REQ, MUL_WAIT, SQR_REQ, SQR_WAIT, DONE.
- **CHECK:**
  - E[0]=1 → MUL_REQ.
  - Else, if bit k is the last bit → DONE.
  - Otherwise → SQR_REQ.
- **Last bit:** k=WIDTH-1, or (with the macro below) the remaining E>>1 == 0.
- **MUL_REQ:** `o_mul_start`=1, a=R, b=B → MUL_WAIT.
- **MUL_WAIT:** on `i_mul_finished`, R←`i_mul_result`. Then last bit → DONE; else → SQR_REQ.
- **SQR_REQ:** `o_mul_start`=1, a=B, b=B → SQR_WAIT.
- **SQR_WAIT:** on `i_mul_finished`, B←`i_mul_result`, E←E>>1, k←k+1 → CHECK.
- **No final square:** squaring after the last bit is never issued.
- **Operand stability:** `o_mul_a`, `o_mul_b` and `o_mul_n` stay stable from the REQ cycle until the `i_mul_finished` cycle inclusive. The multiplier reads its operands every cycle.
- **Spurious finish:** `i_mul_finished` outside the WAIT states is ignored.
- **DONE:** `o_result`←R, `o_finished`=1 for that single cycle → IDLE.
- **exp=0:** result = 1, with no multiplier requests.
- **k counter:** width is clog2(WIDTH)+1 bits; k never wraps.

## Timing
- **Reset:** all outputs are 0 on reset. State=IDLE, R=1, B=E=0.
- **Reset mid-operation:** returns to IDLE immediately. `o_mul_start` drops, and the in-flight product is discarded on its later `i_mul_finished`.
- **Start acceptance:** `i_start` high at edge t → CHECK during cycle t+1, `o_busy`=1.
- **Per processed bit:** 1 (CHECK) + [bit set: 1 + Wm] + [not last: 1 + Ws] cycles.
  - W is the number of cycles from the cycle after REQ up to and including the `i_mul_finished` cycle.
- **DONE:** adds 1 cycle; `o_finished` and the final `o_result` appear in the same cycle.
- **Back-to-back start:** a new start is possible in the cycle after DONE.
- **`o_mul_start`:** registered. Never high for two consecutive cycles. Never high while waiting.

## Configuration
- **`EXP_EARLY_EXIT_EN` defined:** the last bit is also reached when the remaining E>>1 == 0. Latency scales with the exponent's bit length, and exp=0 finishes after one CHECK.
- **`EXP_EARLY_EXIT_EN` undefined:** always walks all WIDTH bits, giving constant-time behaviour (squarings run even when E is exhausted).
- **Both variants:** `o_result` is identical.

## Test plan
Bench multiplier model: returns a·b mod n with fixed W=4 and checks operand stability.

- base=4, exp=13, n=497 → `o_result`=445, one `o_finished` pulse.
- base=2, exp=10, n=1000 → 24. With EXP_EARLY_EXIT_EN: exactly 2 MUL + 3 SQR requests and 3 (last bit) → 4 bits × CHECK + 5×(1+4) + DONE = 30 cycles after acceptance.
- exp=0, base=5, n=7 → `o_result`=1, zero `o_mul_start` pulses. WIDTH-bit mode: WIDTH-1 squarings.
- exp=n-2 for n=97, base=10 → 68 (10·68 mod 97 = 1).
- `i_start` pulsed again while busy → ignored, result unchanged; spurious `i_mul_finished` in CHECK → no state change.
- `i_rst` low during MUL_WAIT → all outputs 0 next cycle. A following start with base=3, exp=5, n=7 → 5.
